// File: rtl/pc_fetch_sequencer.sv
// Multicycle fetch/commit sequencer: owns the architectural PC, requests each
// instruction word, waits for execute and commits the next PC, with halt and traps.
module pc_fetch_sequencer #(
   parameter int unsigned       XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned       ACK_TIMEOUT  = 255,
   parameter int unsigned       CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_active,
   input  logic             run_en,
   input  logic             imem_ack,
   input  logic             exec_done,
   input  logic [1:0]       pc_src,
   input  logic [XLEN-1:0]  br_target,
   input  logic [XLEN-1:0]  jalr_target,
   input  logic             halt_req,
   input  logic             resume,
   output logic [XLEN-1:0]  pc,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   output logic             instr_valid,
   output logic [CNT_W-1:0] instret,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [2:0]       state_dbg
);

   localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_EXEC = 3'd2,
      S_HALT = 3'd3,
      S_TRAP = 3'd4
   } state_e;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
   localparam logic [1:0] CAUSE_MISALGN = 2'b10;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              imem_req_q, imem_req_d;
   logic              instr_valid_q, instr_valid_d;
   logic              trap_q, trap_d;
   logic [1:0]        cause_q, cause_d;
   logic [XLEN-1:0]   next_pc;
   logic [TMO_W-1:0]  tmo_inc;

   // Candidate next PC; pc_src=11 is reserved and behaves as sequential
   always_comb begin
      next_pc = pc_q + XLEN'(4);
      case (pc_src)
         2'b01:   next_pc = br_target;
         2'b10:   next_pc = jalr_target & ~XLEN'(1);
         default: next_pc = pc_q + XLEN'(4);
      endcase
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instret_d     = instret_q;
      tmo_d         = '0;
      instr_valid_d = 1'b0;
      trap_d        = trap_q;
      cause_d       = cause_q;
      tmo_inc       = tmo_q + TMO_W'(1);

      if (load_active) begin
         state_d   = S_IDLE;
         pc_d      = RESET_VECTOR;
         instret_d = '0;
         trap_d    = 1'b0;
         cause_d   = CAUSE_NONE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (run_en) state_d = S_REQ;
            end
            S_REQ: begin
               if (imem_ack) begin
                  instr_valid_d = 1'b1;
                  state_d       = S_EXEC;
               end else if (tmo_inc == TMO_W'(ACK_TIMEOUT)) begin
                  state_d = S_TRAP;
                  trap_d  = 1'b1;
                  cause_d = CAUSE_TIMEOUT;
               end else begin
                  tmo_d = tmo_inc;
               end
            end
            S_EXEC: begin
               if (exec_done) begin
                  if (next_pc[1:0] != 2'b00) begin
                     state_d = S_TRAP;
                     trap_d  = 1'b1;
                     cause_d = CAUSE_MISALGN;
                  end else begin
                     pc_d      = next_pc;
                     instret_d = instret_q + CNT_W'(1);
                     state_d   = halt_req ? S_HALT : S_REQ;
                  end
               end
            end
            S_HALT: begin
               if (resume) state_d = S_REQ;
            end
            S_TRAP: begin
               state_d = S_TRAP;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Request is registered so it lines up with the state it belongs to
      imem_req_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_VECTOR;
         instret_q     <= '0;
         tmo_q         <= '0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         trap_q        <= 1'b0;
         cause_q       <= CAUSE_NONE;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instret_q     <= instret_d;
         tmo_q         <= tmo_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
         trap_q        <= trap_d;
         cause_q       <= cause_d;
      end
   end

   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign imem_req    = imem_req_q;
   assign instr_valid = instr_valid_q;
   assign instret     = instret_q;
   assign trap        = trap_q;
   assign trap_cause  = cause_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus randomized
// retire sequences compared against a transaction-level PC/instret model.
module tb_pc_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic        load_active;
   logic        run_en;
   logic        imem_ack;
   logic        exec_done;
   logic [1:0]  pc_src;
   logic [31:0] br_target;
   logic [31:0] jalr_target;
   logic        halt_req;
   logic        resume;
   logic [31:0] pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        instr_valid;
   logic [31:0] instret;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [2:0]  state_dbg;

   int          n_cmp;
   int          n_err;
   logic [31:0] m_pc;
   logic [31:0] m_ir;
   bit          tr;

   pc_fetch_sequencer #(
      .XLEN(32), .RESET_VECTOR(32'h0000_0000), .ACK_TIMEOUT(4), .CNT_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load_active(load_active), .run_en(run_en),
      .imem_ack(imem_ack), .exec_done(exec_done), .pc_src(pc_src),
      .br_target(br_target), .jalr_target(jalr_target), .halt_req(halt_req),
      .resume(resume), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .instr_valid(instr_valid), .instret(instret), .trap(trap),
      .trap_cause(trap_cause), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural next-PC rule: sequential, branch target, or jalr with bit 0 dropped
   function automatic logic [31:0] ref_target(input logic [1:0] src, input logic [31:0] cur,
                                               input logic [31:0] br, input logic [31:0] jalr);
      case (src)
         2'd1:    return br;
         2'd2:    return jalr & 32'hFFFF_FFFE;
         default: return cur + 32'd4;
      endcase
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_state"},  32'(state_dbg), 32'd0);
      chk({tag, "_pc"},     pc, 32'h0);
      chk({tag, "_req"},    32'(imem_req), 32'd0);
      chk({tag, "_ivalid"}, 32'(instr_valid), 32'd0);
      chk({tag, "_instret"}, instret, 32'd0);
      chk({tag, "_trap"},   32'(trap), 32'd0);
      chk({tag, "_cause"},  32'(trap_cause), 32'd0);
   endtask

   task automatic go_req();
      step();
      chk("enter_req_state", 32'(state_dbg), 32'd1);
      chk("enter_req_req", 32'(imem_req), 32'd1);
   endtask

   // Fetch while in REQ: ack after d cycles, then linger w+1 cycles in EXEC
   task automatic fetch(input int d, input int w);
      for (int i = 0; i < d; i++) begin
         chk("req_wait_req", 32'(imem_req), 32'd1);
         chk("req_wait_addr", imem_addr, m_pc);
         step();
      end
      chk("req_state", 32'(state_dbg), 32'd1);
      chk("req_addr", imem_addr, m_pc);
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      chk("exec_state", 32'(state_dbg), 32'd2);
      chk("ivalid_pulse", 32'(instr_valid), 32'd1);
      chk("exec_req_low", 32'(imem_req), 32'd0);
      for (int i = 0; i <= w; i++) begin
         halt_req = 1'($urandom_range(0, 1));
         resume   = 1'($urandom_range(0, 1));
         imem_ack = 1'($urandom_range(0, 1));
         step();
         halt_req = 1'b0;
         resume   = 1'b0;
         imem_ack = 1'b0;
         chk("exec_hold_state", 32'(state_dbg), 32'd2);
         chk("ivalid_once", 32'(instr_valid), 32'd0);
         chk("exec_pc_hold", pc, m_pc);
      end
   endtask

   task automatic execute(input logic [1:0] src, input logic [31:0] br, input logic [31:0] jalr,
                          input logic hlt, output bit trapped);
      logic [31:0] tgt;
      tgt         = ref_target(src, m_pc, br, jalr);
      exec_done   = 1'b1;
      pc_src      = src;
      br_target   = br;
      jalr_target = jalr;
      halt_req    = hlt;
      step();
      exec_done = 1'b0;
      halt_req  = 1'b0;
      trapped   = (tgt[1:0] != 2'b00);
      if (trapped) begin
         chk("mis_state", 32'(state_dbg), 32'd4);
         chk("mis_trap", 32'(trap), 32'd1);
         chk("mis_cause", 32'(trap_cause), 32'd2);
         chk("mis_pc_hold", pc, m_pc);
         chk("mis_instret_hold", instret, m_ir);
         chk("mis_req", 32'(imem_req), 32'd0);
      end else begin
         m_pc = tgt;
         m_ir = m_ir + 32'd1;
         chk("ret_pc", pc, m_pc);
         chk("ret_instret", instret, m_ir);
         chk("ret_state", 32'(state_dbg), hlt ? 32'd3 : 32'd1);
         chk("ret_req", 32'(imem_req), hlt ? 32'd0 : 32'd1);
      end
   endtask

   task automatic recover(input string tag);
      load_active = 1'b1;
      step();
      load_active = 1'b0;
      m_pc = 32'h0;
      m_ir = 32'h0;
      check_idle(tag);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; load_active = 1'b0; run_en = 1'b0; imem_ack = 1'b0;
      exec_done = 1'b0; pc_src = 2'b00; br_target = '0; jalr_target = '0;
      halt_req = 1'b0; resume = 1'b0;
      m_pc = 32'h0; m_ir = 32'h0;
      step();
      rst_n = 1'b1;
      check_idle("reset");

      // Three sequential retires with a two-cycle ack latency
      run_en = 1'b1;
      go_req();
      for (int k = 0; k < 3; k++) begin
         fetch(2, 0);
         execute(2'b00, 32'h0, 32'h0, 1'b0, tr);
      end
      chk("seq_pc", pc, 32'h0000_000C);
      chk("seq_instret", instret, 32'd3);

      // Branch to 0x40, then jalr 0x81 lands on 0x80
      fetch(1, 1);
      execute(2'b00, 32'h0, 32'h0, 1'b0, tr);
      chk("at_0x10", pc, 32'h10);
      fetch(0, 2);
      execute(2'b01, 32'h40, 32'h0, 1'b0, tr);
      chk("br_pc", pc, 32'h40);
      fetch(3, 0);
      execute(2'b10, 32'h0, 32'h81, 1'b0, tr);
      chk("jalr_pc", pc, 32'h80);

      // Misaligned branch traps; trap ignores everything until load_active
      fetch(1, 0);
      execute(2'b01, 32'h42, 32'h0, 1'b0, tr);
      chk("mis_flag", 32'(tr), 32'd1);
      for (int k = 0; k < 3; k++) begin
         exec_done = 1'b1; resume = 1'b1; imem_ack = 1'b1;
         pc_src = 2'b01; br_target = 32'h100;
         step();
         exec_done = 1'b0; resume = 1'b0; imem_ack = 1'b0;
         chk("trap_hold_state", 32'(state_dbg), 32'd4);
         chk("trap_hold_pc", pc, 32'h80);
         chk("trap_hold_req", 32'(imem_req), 32'd0);
      end
      recover("load_clear");

      // Fetch timeout after four unanswered REQ cycles
      go_req();
      for (int k = 0; k < 3; k++) begin
         step();
         chk("tmo_req_hi", 32'(imem_req), 32'd1);
         chk("tmo_state", 32'(state_dbg), 32'd1);
      end
      step();
      chk("tmo_trap_state", 32'(state_dbg), 32'd4);
      chk("tmo_trap", 32'(trap), 32'd1);
      chk("tmo_cause", 32'(trap_cause), 32'd1);
      chk("tmo_req_lo", 32'(imem_req), 32'd0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      m_pc = 32'h0; m_ir = 32'h0;
      check_idle("tmo_reset");

      // Halt at pc=8, hold, then resume into REQ at 0xC
      go_req();
      fetch(1, 0); execute(2'b00, 32'h0, 32'h0, 1'b0, tr);
      fetch(2, 1); execute(2'b00, 32'h0, 32'h0, 1'b0, tr);
      fetch(0, 0); execute(2'b00, 32'h0, 32'h0, 1'b1, tr);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("halt_state", 32'(state_dbg), 32'd3);
         chk("halt_pc", pc, 32'hC);
         chk("halt_req_lo", 32'(imem_req), 32'd0);
      end
      resume = 1'b1;
      step();
      resume = 1'b0;
      chk("resume_state", 32'(state_dbg), 32'd1);
      chk("resume_addr", imem_addr, 32'hC);
      chk("resume_req", 32'(imem_req), 32'd1);

      // Reset mid-REQ with instret=5, then an ack in the first REQ cycle
      fetch(1, 0); execute(2'b00, 32'h0, 32'h0, 1'b0, tr);
      fetch(0, 1); execute(2'b00, 32'h0, 32'h0, 1'b0, tr);
      chk("pre_reset_instret", instret, 32'd5);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      m_pc = 32'h0; m_ir = 32'h0;
      check_idle("midreq_reset");
      go_req();
      fetch(0, 0);
      execute(2'b00, 32'h0, 32'h0, 1'b0, tr);

      // load_active abandons an in-flight fetch
      step();
      recover("load_midfetch");

      // PC wraps modulo 2^32
      go_req();
      fetch(0, 0); execute(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, tr);
      fetch(1, 0); execute(2'b00, 32'h0, 32'h0, 1'b0, tr);
      chk("wrap_pc", pc, 32'h0);

      // Randomized retire stream
      for (int k = 0; k < 40; k++) begin
         logic [1:0]  src;
         logic [31:0] br, jalr;
         logic        hlt;
         src  = 2'($urandom_range(0, 3));
         br   = $urandom & 32'hFFFF_FFFC;
         jalr = $urandom & 32'hFFFF_FFFD;
         if ($urandom_range(0, 5) == 0) br = br | 32'h2;
         if ($urandom_range(0, 5) == 0) jalr = jalr | 32'h2;
         hlt = ($urandom_range(0, 4) == 0);
         fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         execute(src, br, jalr, hlt, tr);
         if (tr) begin
            recover("rnd_recover");
            go_req();
         end else if (hlt) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
               step();
               chk("rnd_halt_pc", pc, m_pc);
            end
            resume = 1'b1;
            step();
            resume = 1'b0;
            chk("rnd_resume_addr", imem_addr, m_pc);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
